// File: rtl/mem_responder.sv
// Word-organised data RAM behind a ready/valid port with fixed access latency.
// Optional MEM_MISALIGN_CHECK_EN flags misaligned word/half accesses via resp_err.
module mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = DEPTH_LOG2 + 2;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic          we_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic          accept;
  logic          fire;

  logic [31:0]   mem [2**DEPTH_LOG2];

  logic          unused_addr;
  assign unused_addr = ^req_addr[31:AW];

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept   = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: if (cnt == '0) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // the access happens on the WAIT->DONE edge
  assign fire = (state == WAIT) && (cnt == '0);

  logic [AW-1:0] ea;
  logic          mis;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   cur;
  logic [31:0]   merged;
  logic [31:0]   shifted;
  logic [31:0]   ld;

  always_comb begin
    ea  = addr_q;
    mis = 1'b0;
    unique case (size_q)
      2'b00: ;
      2'b01: begin
`ifdef MEM_MISALIGN_CHECK_EN
        mis = ea[0];
`else
        ea[0] = 1'b0;
`endif
      end
      default: begin
`ifdef MEM_MISALIGN_CHECK_EN
        mis = |ea[1:0];
`else
        ea[1:0] = 2'b00;
`endif
      end
    endcase

    unique case (size_q)
      2'b00: begin
        be    = 4'b0001 << ea[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = ea[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata_q;
      end
    endcase

    cur = mem[ea[AW-1:2]];
    for (int i = 0; i < 4; i++) begin
      merged[8*i+:8] = be[i] ? wlane[8*i+:8] : cur[8*i+:8];
    end

    shifted = cur >> {ea[1:0], 3'b000};
    unique case (size_q)
      2'b00:   ld = {24'h0, shifted[7:0]};
      2'b01:   ld = {16'h0, shifted[15:0]};
      default: ld = cur;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        addr_q  <= req_addr[AW-1:0];
        wdata_q <= req_wdata;
        cnt     <= CW'(LATENCY - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (fire) begin
        rdata_q <= (we_q || mis) ? 32'h0 : ld;
        err_q   <= mis;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && fire && we_q && !mis) begin
      mem[ea[AW-1:2]] <= merged;
    end
  end

  assign resp_valid = (state == DONE) && !reset;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a word-array reference model
// and a per-cycle response checker (latency, data, error flag).
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  mem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model_mem [256];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
    end
  endtask

  // reference: plain shift/mask arithmetic on a word array
  task automatic model(input logic we, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
    int idx;
    int off;
    int nbytes;
    logic [31:0] mask;
    idx    = int'((a >> 2) % 256);
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off    = int'(a % 4);
    err    = 1'b0;
    if (off % nbytes != 0) begin
`ifdef MEM_MISALIGN_CHECK_EN
      err = 1'b1;
`endif
      off = off - (off % nbytes);
    end
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 1);
    rd = 32'h0;
    if (!err) begin
      if (we) begin
        model_mem[idx] = (model_mem[idx] & ~(mask << (8 * off)))
                       | ((wd & mask) << (8 * off));
      end else begin
        rd = (model_mem[idx] >> (8 * off)) & mask;
      end
    end
  endtask

  task automatic send(input logic we, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      input bit keep, input bit abort,
                      input bit pin, input logic [31:0] lit,
                      output int acc);
    int n;
    exp_t e;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: addr 0x%08h not accepted", a);
      req_valid = 1'b0;
      return;
    end
    if (!abort) begin
      model(we, sz, a, wd, e.rdata, e.err);
      e.acc = cyc;
      q.push_back(e);
      if (pin) check("model_pin", e.rdata, lit);
    end
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
    if (abort) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d responses outstanding", q.size());
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got resp_valid=1 want 0");
      end else begin
        exp_t e;
        e = q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        check("latency", cyc - e.acc, LAT + 1);
      end
    end
  end

  initial begin
    int a0;
    int a1;
    logic [31:0] lit_cafe;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 2'b00;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", {31'h0, resp_err}, 32'h0);

    send(1, 2'b10, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, a0);
    send(0, 2'b10, 32'h10, 32'h0, 0, 0, 1, 32'hDEADBEEF, a0);

    send(1, 2'b10, 32'h10, 32'h11223344, 0, 0, 0, 0, a0);
    send(1, 2'b00, 32'h11, 32'hFFFF_FFAA, 0, 0, 0, 0, a0);
    send(0, 2'b10, 32'h10, 32'h0, 0, 0, 1, 32'h1122AA44, a0);
    send(0, 2'b00, 32'h13, 32'h0, 0, 0, 1, 32'h00000011, a0);
    send(0, 2'b00, 32'h10, 32'h0, 0, 0, 1, 32'h00000044, a0);
    send(0, 2'b11, 32'h410, 32'h0, 0, 0, 1, 32'h1122AA44, a0);

    send(1, 2'b10, 32'h20, 32'h0, 0, 0, 0, 0, a0);
    send(1, 2'b01, 32'h22, 32'h1234BEEF, 0, 0, 0, 0, a0);
    send(0, 2'b01, 32'h22, 32'h0, 0, 0, 1, 32'h0000BEEF, a0);
    send(0, 2'b10, 32'h20, 32'h0, 0, 0, 1, 32'hBEEF0000, a0);
    send(0, 2'b01, 32'h20, 32'h0, 0, 0, 1, 32'h00000000, a0);

    send(1, 2'b10, 32'h0, 32'hA5A50000, 0, 0, 0, 0, a0);
    send(1, 2'b10, 32'h4, 32'h00005A5A, 0, 0, 0, 0, a0);
    drain();
    send(0, 2'b10, 32'h0, 32'h0, 1, 0, 1, 32'hA5A50000, a0);
    send(0, 2'b10, 32'h4, 32'h0, 0, 0, 1, 32'h00005A5A, a1);
    check("accept_spacing", a1 - a0, LAT + 2);
    drain();

    send(1, 2'b10, 32'h30, 32'h12345678, 0, 0, 0, 0, a0);
    drain();
    send(1, 2'b10, 32'h30, 32'h55555555, 0, 1, 0, 0, a0);
    repeat (6) @(negedge clk);
    send(0, 2'b10, 32'h30, 32'h0, 0, 0, 1, 32'h12345678, a0);

    send(1, 2'b10, 32'h40, 32'h0, 0, 0, 0, 0, a0);
    send(1, 2'b10, 32'h41, 32'hCAFEF00D, 0, 0, 0, 0, a0);
`ifdef MEM_MISALIGN_CHECK_EN
    lit_cafe = 32'h0;
`else
    lit_cafe = 32'hCAFEF00D;
`endif
    send(0, 2'b10, 32'h40, 32'h0, 0, 0, 1, lit_cafe, a0);
    drain();
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's address path. It services one load or store per request at the 32-bit byte address driven by the datapath's address-select stage.
- Holds a word-organised data RAM and models a fixed access latency through a ready/valid handshake.
- Performs byte and halfword stores by read-modify-write.
- Returns load data right-justified and zero-extended; the datapath performs sign extension.

Parameters:
- DEPTH_LOG2, 8, log2 of RAM depth in 32-bit words (256 words default).
- LATENCY, 2, wait cycles between request accept and response. Must be >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle pulse: access complete.
- resp_rdata  output  32  load data, zero-extended; 0 for stores.
- resp_err  output  1  misaligned access flag, valid with resp_valid.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; req_ready = 1; resp_valid = 0; resp_rdata = 0; resp_err = 0; wait counter = 0.
  - RAM contents are not cleared.
- States: IDLE, WAIT, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, capture we/size/addr/wdata, load the counter with LATENCY-1, and go to WAIT.
  - With no request, stay in IDLE.
- WAIT:
  - req_ready = 0.
  - Decrement the counter each cycle; at 0, go to DONE. WAIT therefore lasts exactly LATENCY cycles.
- DONE:
  - Perform the access on the entry edge.
  - Assert resp_valid for exactly one cycle with rdata/err, then return to IDLE.
  - req_ready = 0 in DONE.
  - Minimum spacing between accepts is LATENCY+2 cycles.
- Accept-to-response latency: resp_valid is high LATENCY+1 cycles after the accepting edge.
- Inputs are sampled only at accept. Changes during WAIT/DONE are ignored.
- Word index = addr[DEPTH_LOG2+1:2]. Higher address bits are ignored, so addresses wrap modulo 4*2^DEPTH_LOG2 bytes.
- Little-endian lane selection:
  - Byte: lane addr[1:0].
  - Half: lane addr[1] (bits [15:0] when addr[1]=0, [31:16] when 1).
- Loads: select the lane and zero-extend into resp_rdata.
- Stores: read the word, merge the new lane(s) from wdata's low bits, write the full word back. Other lanes are untouched. resp_rdata = 0.
- Reset asserted in WAIT or DONE: abort the access, perform no RAM write, go to IDLE. resp_valid stays low.
- req_valid held high in IDLE across consecutive requests: each is accepted only when req_ready = 1. No request is lost or duplicated.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- Defined:
  - Misalignment is word with addr[1:0] != 00, or half with addr[0] != 0.
  - A misaligned access performs no RAM write.
  - The response carries resp_err = 1 and resp_rdata = 0, with normal latency.
  - resp_err is intended to drive the CPU's exception entry.
- Undefined:
  - Word accesses force addr[1:0] to 00; half accesses force addr[0] to 0.
  - resp_err is tied 0.

Test Plan:
- After reset, store word 0xDEADBEEF at 0x10 (LATENCY=2); load word at 0x10 -> resp_valid 3 cycles after each accept, rdata = 0xDEADBEEF, err = 0.
- Store byte 0xAA at 0x11 over word 0x11223344 at 0x10, then load word 0x10 -> 0x1122AA44. Load byte 0x13 -> 0x00000011.
- Store half 0xBEEF at 0x22 over 0x00000000 at 0x20; load half 0x22 -> 0x0000BEEF; load word 0x20 -> 0xBEEF0000.
- req_valid held high for back-to-back loads at 0x0 and 0x4 -> exactly two accepts, spaced 4 cycles apart, with two resp_valid pulses in order.
- Assert reset during WAIT of a store of 0x55555555 to 0x30 (prior value 0x12345678) -> no resp_valid; later load of 0x30 -> 0x12345678.
- With MEM_MISALIGN_CHECK_EN: store word to 0x41 -> err = 1, RAM unchanged. Without it: the same store writes word 0x40.
